hv_ang_samp_ctrl: RTL
=====================

// Module: hv_ang_samp_ctrl
// PURPOSE
//  Arbiter/sequencer for the shared analog read-back path (cap trim VBN codes, dead-time counter).
//  Two level requesters (cap trim read, cnt_del read) are served one at a time with round-robin priority.
//  Per grant: drive one-hot channel select, wait a 2us settle window, capture the value,
//  return a 1-cycle ack with the data held in an output register, then insert a break-before-make guard cycle.
// PARAMETERS
//  CLK_M        48                               core clock frequency in MHz
//  SAMP_CYC_NUM (2001*CLK_M+999)/1000 (=97)      settle cycles before capture (>=2us); derived localparam
//  CNT_W        $clog2(SAMP_CYC_NUM+1)           settle counter width; derived localparam
// PORTS
//  i_clk                 in   1  core clock, all logic on rising edge
//  i_rst_n               in   1  reset, synchronous, active-low
//  i_req_cap             in   1  level request: sample cap trim code; held until o_ack_cap
//  i_req_del             in   1  level request: sample cnt_del; held until o_ack_del
//  i_off_vbn_read        in   4  analog off-side VBN code, valid only after settle
//  i_on_vbn_read         in   4  analog on-side VBN code, valid only after settle
//  i_cnt_del_read        in   6  analog dead-time count, valid only after settle
//  o_sel_cap             out  1  enable cap trim read-back channel
//  o_sel_del             out  1  enable cnt_del read-back channel
//  o_busy                out  1  FSM not in IDLE
//  o_ack_cap             out  1  1-cycle pulse: o_cap_trim_code_read updated
//  o_ack_del             out  1  1-cycle pulse: o_cnt_del_read updated
//  o_cap_trim_code_read  out  8  {off_vbn, on_vbn} captured value
//  o_cnt_del_read        out  6  captured cnt_del value
// BEHAVIOUR
//  Reset (i_rst_n=0 at edge, any state): state=IDLE, cnt=0, all outputs 0, last_grant=DEL.
//  FSM states: IDLE -> SETTLE -> CAPTURE -> GUARD -> IDLE. All outputs are registered.
//  IDLE:
//   - No request: stay in IDLE.
//   - One request: grant it.
//   - Both requests: grant the channel opposite last_grant. First grant after reset is CAP.
//   - On grant: go to SETTLE, cnt<=0, update last_grant.
//  SETTLE:
//   - cnt increments each cycle.
//   - When cnt==SAMP_CYC_NUM-1, go to CAPTURE.
//   - cnt never exceeds SAMP_CYC_NUM-1; no wrap.
//  CAPTURE (1 cycle):
//   - Load the output register of the granted channel from its inputs.
//   - Pulse the granted ack.
//   - Go to GUARD.
//  GUARD (1 cycle): no select, no ack; go to IDLE.
//  Select and ack outputs:
//   - o_sel_x=1 exactly while in SETTLE or CAPTURE for channel x.
//   - Selects are one-hot or zero, never both high.
//   - o_ack_x and the new data value appear together in the GUARD cycle.
//   - The non-granted output register is never modified.
//  Timing: request sampled high at edge 0 ->
//   - o_sel high cycles 1..SAMP_CYC_NUM+1.
//   - ack plus data in cycle SAMP_CYC_NUM+2, o_sel=0 in that cycle.
//   - IDLE in cycle SAMP_CYC_NUM+3.
//  Requester handshake: drop the request in the ack cycle. A request still high when IDLE is reached is a new request.
//  Abort: if the granted request drops during SETTLE or CAPTURE, go to GUARD next cycle.
//   - No ack.
//   - Output register unchanged.
//   - last_grant keeps the aborted channel.
//  The non-granted request is ignored until IDLE. It is served next, after the guard cycle.
//  Widths: concatenation is exactly {i_off_vbn_read, i_on_vbn_read}, no extension or truncation.
// TESTING (run with CLK_M=4 -> SAMP_CYC_NUM=9)
//  1. Reset: i_rst_n=0 for 2 cycles mid-SETTLE -> next cycle IDLE, all outputs 0, cnt=0.
//  2. Single cap request: i_req_cap=1, off=4'hA, on=4'h5 ->
//     o_sel_cap cycles 1..10; o_ack_cap and o_cap_trim_code_read=8'hA5 in cycle 11; o_busy=0 cycle 12.
//  3. Both requests high together from reset ->
//     CAP served first, then after GUARD DEL served (i_cnt_del_read=6'h2B -> o_cnt_del_read=6'h2B).
//     o_sel_cap and o_sel_del never overlap; at least one cycle with both selects low.
//  4. Round-robin: both held high continuously, reassert after each ack -> grants alternate CAP, DEL, CAP, DEL.
//  5. Abort: i_req_del dropped at SETTLE cnt=4 ->
//     GUARD next cycle, no o_ack_del, o_cnt_del_read unchanged, IDLE after.
//  6. Settle correctness: inputs change value every cycle during SETTLE ->
//     captured value equals the input sampled in the CAPTURE cycle only.

Source files
------------

// File: rtl/hv_ang_samp_ctrl.sv
// Round-robin sequencer for the shared analog read-back path (cap trim VBN codes, dead-time count).
// Each grant selects one channel, waits out the settle window, captures, acks and leaves a guard cycle.
module hv_ang_samp_ctrl #(
  parameter int CLK_M = 48
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_cap,
  input  logic       i_req_del,
  input  logic [3:0] i_off_vbn_read,
  input  logic [3:0] i_on_vbn_read,
  input  logic [5:0] i_cnt_del_read,
  output logic       o_sel_cap,
  output logic       o_sel_del,
  output logic       o_busy,
  output logic       o_ack_cap,
  output logic       o_ack_del,
  output logic [7:0] o_cap_trim_code_read,
  output logic [5:0] o_cnt_del_read
);

  localparam int SAMP_CYC_NUM = (2001 * CLK_M + 999) / 1000;
  localparam int CNT_W        = $clog2(SAMP_CYC_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMP_CYC_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_GUARD   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_del_reg, last_del_next;
  logic             sel_cap_reg, sel_cap_next;
  logic             sel_del_reg, sel_del_next;
  logic             busy_reg, busy_next;
  logic             ack_cap_reg, ack_cap_next;
  logic             ack_del_reg, ack_del_next;
  logic [7:0]       cap_data_reg, cap_data_next;
  logic [5:0]       del_data_reg, del_data_next;
  logic             granted_req;
  logic             sel_active;

  // last_del_reg doubles as the identity of the channel currently being served.
  assign granted_req = last_del_reg ? i_req_del : i_req_cap;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_del_next = last_del_reg;
    cap_data_next = cap_data_reg;
    del_data_next = del_data_reg;
    ack_cap_next  = 1'b0;
    ack_del_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_req_cap || i_req_del) begin
          state_next    = ST_SETTLE;
          cnt_next      = '0;
          // DEL wins only if CAP is absent or CAP was served last.
          last_del_next = i_req_del && (!i_req_cap || !last_del_reg);
        end
      end
      ST_SETTLE: begin
        if (!granted_req) begin
          state_next = ST_GUARD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_CAPTURE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_next = ST_GUARD;
        if (granted_req) begin
          if (last_del_reg) begin
            ack_del_next  = 1'b1;
            del_data_next = i_cnt_del_read;
          end else begin
            ack_cap_next  = 1'b1;
            cap_data_next = {i_off_vbn_read, i_on_vbn_read};
          end
        end
      end
      ST_GUARD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    sel_active   = (state_next == ST_SETTLE) || (state_next == ST_CAPTURE);
    sel_cap_next = sel_active && !last_del_next;
    sel_del_next = sel_active && last_del_next;
    busy_next    = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      last_del_reg <= 1'b1;
      sel_cap_reg  <= 1'b0;
      sel_del_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      ack_cap_reg  <= 1'b0;
      ack_del_reg  <= 1'b0;
      cap_data_reg <= '0;
      del_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_del_reg <= last_del_next;
      sel_cap_reg  <= sel_cap_next;
      sel_del_reg  <= sel_del_next;
      busy_reg     <= busy_next;
      ack_cap_reg  <= ack_cap_next;
      ack_del_reg  <= ack_del_next;
      cap_data_reg <= cap_data_next;
      del_data_reg <= del_data_next;
    end
  end

  assign o_sel_cap            = sel_cap_reg;
  assign o_sel_del            = sel_del_reg;
  assign o_busy               = busy_reg;
  assign o_ack_cap            = ack_cap_reg;
  assign o_ack_del            = ack_del_reg;
  assign o_cap_trim_code_read = cap_data_reg;
  assign o_cnt_del_read       = del_data_reg;

endmodule
